// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage: icode values,
// stage state encoding and icode classification helpers.
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] RSP = 4'd4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR_RESP
  } state_e;

  function automatic logic is_wr(input logic [3:0] ic);
    return (ic == RMMOVQ) || (ic == CALL) || (ic == PUSHQ);
  endfunction

  function automatic logic is_rd(input logic [3:0] ic);
    return (ic == MRMOVQ) || (ic == RET) || (ic == POPQ);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-addressed data memory, 64-bit little-endian word port.
// Ports: clk, we, addr (byte address), wdata (store), rdata (load).
module dmem_array #(
  parameter int MEM_BYTES = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_BYTES)-1:0] addr,
  input  logic [63:0]                  wdata,
  output logic [63:0]                  rdata
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        mem[addr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[addr + AW'(i)];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: captures execute results, performs the data
// memory access over LATENCY cycles, presents the writeback bundle.
// Ports: in_* handshake + execute fields, out_* handshake, *_q
// forwarded fields, valM load data, dmem_error range fault.
module mem_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cond,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode_q,
  output logic [3:0]  rA_q,
  output logic [3:0]  rB_q,
  output logic        cond_q,
  output logic [63:0] valE_q,
  output logic [63:0] valM,
  output logic        dmem_error
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    icode_d, rA_d, rB_d;
  logic          cond_d;
  logic [63:0]   valE_d;
  logic [63:0]   valm_q, valm_d;
  logic          err_q, err_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;

  logic [63:0]   acc_addr, acc_data, rdata;
  logic          mem_op, in_range, last, we;

  always_comb begin
    acc_addr = valE;
    acc_data = valA;
    unique case (1'b1)
      (icode == RET) || (icode == POPQ): acc_addr = valA;
      (icode == CALL):                   acc_data = valP;
      default: ;
    endcase
  end

  assign mem_op   = is_wr(icode) || is_rd(icode);
  // Compare against MEM_BYTES-8 so A+7 is never formed (no wrap).
  assign in_range = acc_addr <= ADDR_MAX;
  assign last     = (state_q == ACCESS) && (cnt_q == CNT_LAST);
  // Reset beats the commit edge.
  assign we       = last && wr_q && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    icode_d = icode_q;
    rA_d    = rA_q;
    rB_d    = rB_q;
    cond_d  = cond_q;
    valE_d  = valE_q;
    valm_d  = valm_q;
    err_d   = err_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          icode_d = icode;
          rA_d    = rA;
          rB_d    = rB;
          cond_d  = cond;
          valE_d  = valE;
          valm_d  = '0;
          err_d   = mem_op && !in_range;
          wr_d    = is_wr(icode) && in_range;
          rd_d    = is_rd(icode) && in_range;
          addr_d  = acc_addr[AW-1:0];
          wdata_d = acc_data;
          cnt_d   = '0;
          state_d = mem_op ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          if (rd_q) valm_d = rdata;
          state_d = err_q ? ERR_RESP : RESP;
        end
      end
      RESP, ERR_RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      icode_q <= '0;
      rA_q    <= '0;
      rB_q    <= '0;
      cond_q  <= 1'b0;
      valE_q  <= '0;
      valm_q  <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      icode_q <= icode_d;
      rA_q    <= rA_d;
      rB_q    <= rB_d;
      cond_q  <= cond_d;
      valE_q  <= valE_d;
      valm_q  <= valm_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == RESP) || (state_q == ERR_RESP);
  assign valM       = valm_q;
  assign dmem_error = err_q;

  dmem_array #(
    .MEM_BYTES(MEM_BYTES)
  ) u_dmem (
    .clk  (clk),
    .we   (we),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed steps plus random instructions
// checked against a byte-array reference model.
module tb_mem_stage;

  localparam int MB  = 1024;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  icode = '0;
  logic [3:0]  rA = '0;
  logic [3:0]  rB = '0;
  logic        cond = 1'b0;
  logic [63:0] valE = '0;
  logic [63:0] valA = '0;
  logic [63:0] valP = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  icode_q, rA_q, rB_q;
  logic        cond_q;
  logic [63:0] valE_q, valM;
  logic        dmem_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [MB];

  mem_stage #(
    .MEM_BYTES(MB),
    .LATENCY  (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .rA        (rA),
    .rB        (rB),
    .cond      (cond),
    .valE      (valE),
    .valA      (valA),
    .valP      (valP),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .icode_q   (icode_q),
    .rA_q      (rA_q),
    .rB_q      (rB_q),
    .cond_q    (cond_q),
    .valE_q    (valE_q),
    .valM      (valM),
    .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the instruction should return, and its
  // architectural effect on memory.
  function automatic void model(input logic [3:0] ic,
                                input logic [63:0] e,
                                input logic [63:0] a,
                                input logic [63:0] p,
                                output logic [63:0] vm,
                                output logic err,
                                output int lat);
    logic        st, ld;
    logic [63:0] ad, dat;
    int          base;
    st  = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    ld  = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    ad  = (ic == 4'h9 || ic == 4'hB) ? a : e;
    dat = (ic == 4'h8) ? p : a;
    vm  = '0;
    err = 1'b0;
    lat = (st || ld) ? LAT + 1 : 1;
    if (st || ld) begin
      if (ad >= 64'(MB) || 64'(MB) - ad < 64'd8) begin
        err = 1'b1;
      end else begin
        base = int'(ad);
        for (int i = 0; i < 8; i++) begin
          if (st) ref_mem[base + i] = dat[8*i +: 8];
          else vm[8*i +: 8] = ref_mem[base + i];
        end
      end
    end
  endfunction

  task automatic run(input logic [3:0] ic,
                     input logic [3:0] ra,
                     input logic [3:0] rb,
                     input logic c,
                     input logic [63:0] e,
                     input logic [63:0] a,
                     input logic [63:0] p,
                     input int hold,
                     input string tag);
    logic [63:0]  exp_vm;
    logic         exp_err;
    int           exp_lat;
    int           k;
    logic [151:0] snap;
    model(ic, e, a, p, exp_vm, exp_err, exp_lat);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    icode = ic; rA = ra; rB = rb; cond = c;
    valE = e; valA = a; valP = p;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    icode = 4'($urandom); rA = 4'($urandom);
    rB = 4'($urandom); cond = 1'($urandom);
    valE = {$urandom, $urandom};
    valA = {$urandom, $urandom};
    valP = {$urandom, $urandom};
    k = 1;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, ".lat"}, 64'(k), 64'(exp_lat));
    chk({tag, ".valM"}, valM, exp_vm);
    chk({tag, ".err"}, 64'(dmem_error), 64'(exp_err));
    chk({tag, ".icode_q"}, 64'(icode_q), 64'(ic));
    chk({tag, ".rA_q"}, 64'(rA_q), 64'(ra));
    chk({tag, ".rB_q"}, 64'(rB_q), 64'(rb));
    chk({tag, ".cond_q"}, 64'(cond_q), 64'(c));
    chk({tag, ".valE_q"}, valE_q, e);
    snap = {out_valid, dmem_error, icode_q, rA_q, rB_q,
            cond_q, valE_q, valM, 6'd0};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold"},
          {out_valid, dmem_error, icode_q, rA_q, rB_q,
           cond_q, valE_q, valM, 6'd0} == snap ? 64'd1 : 64'd0,
          64'd1);
      chk({tag, ".hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drained"}, 64'(out_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 64'(MB - 7) + 64'($urandom_range(0, 20));
      1: return {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      2: return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      3: return 64'(MB - 8);
      default: return 64'($urandom_range(0, 248));
    endcase
  endfunction

  initial begin
    logic [3:0]  ic;
    logic [63:0] ea, aa, d, w;
    logic [63:0] exp_vm;
    logic        exp_err;
    int          exp_lat;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.valM", valM, 64'd0);
    chk("rst.err", 64'(dmem_error), 64'd0);
    chk("rst.fields",
        {icode_q, rA_q, rB_q, 3'd0, cond_q, valE_q[47:0]},
        64'd0);
    chk("rst.valE_q", valE_q, 64'd0);
    rst = 1'b0;

    // Give the region used by loads known contents.
    for (int i = 0; i < 32; i++) begin
      run(4'h4, 4'd1, 4'd2, 1'b0, 64'(8 * i),
          {$urandom, $urandom}, 64'd0, 0, "init");
    end
    run(4'h4, 4'd1, 4'd2, 1'b0, 64'(MB - 8),
        {$urandom, $urandom}, 64'd0, 0, "init_top");

    run(4'h4, 4'd3, 4'd5, 1'b0, 64'd16,
        64'h1122_3344_5566_7788, 64'd0, 0, "rmmovq");
    run(4'h5, 4'd6, 4'd5, 1'b0, 64'd16,
        64'd0, 64'd0, 0, "mrmovq");
    chk("byte16", 64'(dut.u_dmem.mem[16]), 64'h88);

    run(4'hA, 4'd7, 4'd4, 1'b0, 64'd24,
        64'd5, 64'd0, 0, "pushq");
    run(4'hB, 4'd7, 4'd4, 1'b0, 64'd32,
        64'd24, 64'd0, 0, "popq");

    run(4'h5, 4'd1, 4'd1, 1'b0, 64'(MB - 7),
        64'd0, 64'd0, 0, "ld_oor");
    run(4'h5, 4'd1, 4'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC,
        64'd0, 64'd0, 0, "ld_wrap");
    run(4'h4, 4'd1, 4'd1, 1'b0, 64'h100_0000_0010,
        64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 0, "st_oor");
    run(4'h5, 4'd1, 4'd1, 1'b0, 64'd16,
        64'd0, 64'd0, 0, "ld_after_oor");

    run(4'h6, 4'd2, 4'd3, 1'b1, 64'd99,
        64'd0, 64'd0, 0, "opq");
    run(4'h8, 4'd4, 4'd4, 1'b0, 64'd40,
        64'd0, 64'h0BAD_CAFE_1234_5678, 5, "call_bp");
    run(4'h9, 4'd4, 4'd4, 1'b0, 64'd48,
        64'd40, 64'd0, 5, "ret_bp");
    run(4'h2, 4'd1, 4'd2, 1'b1, 64'd7,
        64'd0, 64'd0, 5, "rrmov_bp");

    for (int n = 0; n < 80; n++) begin
      ic = 4'($urandom_range(0, 11));
      ea = pick_addr();
      aa = (ic == 4'h9 || ic == 4'hB) ? pick_addr()
                                      : {$urandom, $urandom};
      d  = {$urandom, $urandom};
      run(ic, 4'($urandom), 4'($urandom), 1'($urandom),
          ea, aa, d, $urandom_range(0, 3), "rnd");
    end

    // Reset lands on the commit edge of a store: store is lost.
    model(4'h5, 64'd0, 64'd0, 64'd0, exp_vm, exp_err, exp_lat);
    icode = 4'h4; valE = 64'd0; valA = 64'd7;
    valP = 64'd0; rA = 4'd1; rB = 4'd2; cond = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst.in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst.valE_q", valE_q, 64'd0);
    chk("mid_rst.icode_q", 64'(icode_q), 64'd0);
    w = '0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = dut.u_dmem.mem[i];
    chk("mid_rst.mem", w, exp_vm);
    rst = 1'b0;
    @(posedge clk); #1;
    run(4'h5, 4'd1, 4'd1, 1'b0, 64'd0,
        64'd0, 64'd0, 0, "ld_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Y86-64 sequential-processor memory stage that produces the operand bundle consumed by the writeback/register-file stage. It accepts one instruction's execute results (icode, rA, rB, cond, valE, valA, valP) through a valid/ready handshake. It performs the data-memory read or write that icode demands against an internal little-endian byte array, then presents valM together with the forwarded writeback fields until writeback accepts them. Access latency is a parameter, so the stage models a multi-cycle data memory.

## Interface
- MEM_BYTES, 1024: data memory size in bytes; a power of two and at least 8.
- LATENCY, 2: cycles spent in ACCESS per memory instruction; at least 1.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute results are valid.
- in_ready  out  1  stage can accept; high only in IDLE.
- icode  in  4  instruction code.
- rA, rB  in  4  register IDs, forwarded unchanged.
- cond  in  1  condition flag, forwarded unchanged.
- valE  in  64  ALU result or address.
- valA  in  64  store data, or pop/ret address.
- valP  in  64  next PC; the call store data.
- out_valid  out  1  writeback bundle valid.
- out_ready  in  1  writeback accepts the bundle.
- icode_q, rA_q, rB_q, cond_q, valE_q  out  4/4/4/1/64  registered copies of the inputs.
- valM  out  64  loaded value; 0 for non-loads and on error.
- dmem_error  out  1  the captured instruction had an out-of-range address.

## Operation
- Handshake:
  - An instruction is captured on a posedge with in_valid && in_ready; all inputs are registered at that edge.
  - The bundle is consumed on a posedge with out_valid && out_ready.
- States and transitions:
  - IDLE to ACCESS on capture of a memory icode.
  - IDLE to RESP on capture of any other icode.
  - ACCESS to RESP or ERR_RESP after LATENCY cycles.
  - RESP or ERR_RESP to IDLE on consume.
- Address and data per icode (A = access address, D = store data):
  - rmmovq (4): write, A=valE, D=valA.
  - mrmovq (5): read, A=valE.
  - call (8): write, A=valE, D=valP.
  - ret (9): read, A=valA.
  - pushq (A): write, A=valE, D=valA.
  - popq (B): read, A=valA.
  - All other icodes perform no access and leave valM=0.
- Width and layout:
  - A is an unsigned 64-bit value.
  - Bytes A..A+7 are accessed little-endian: byte A maps to bits [7:0].
  - No alignment is required.
- Range check at capture: the access is in range iff A <= MEM_BYTES-8, computed without overflow. An out-of-range access never writes and never reads, and the stage ends in ERR_RESP with dmem_error=1 and valM=0.
- Store commit: all 8 bytes are written on the final ACCESS edge, never earlier. The memory array is not cleared by reset.
- Loads: valM is registered on the final ACCESS edge and held stable through RESP.
- Forwarded fields: icode_q, rA_q, rB_q, cond_q and valE_q are held from capture until consume.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - valM=0, dmem_error=0.
  - All *_q outputs are 0.
- Latency from capture edge to out_valid:
  - Non-memory icode: 1 cycle.
  - Memory icode, in or out of range: LATENCY+1 cycles. Error timing is identical to a normal access, so no early exit.
- Backpressure: out_valid and every output stay stable while out_ready=0. in_ready stays 0 outside IDLE, so no new capture occurs while a bundle is pending.
- A consume edge returns the stage to IDLE, and in_ready rises in the following cycle. Throughput is one instruction per LATENCY+2 cycles for memory ops and one per 2 cycles otherwise.
- Reset mid-operation:
  - rst during ACCESS abandons the store, and memory is unchanged unless the commit edge has already passed.
  - rst during RESP drops the bundle.
  - rst has priority over capture, commit and consume on the same edge.
- A load from an address written by the immediately preceding instruction returns the new data, because the commit precedes the next capture.

## Structure
- Package y86_pkg holds the icode constants (HALT..POPQ, 4'h0..4'hB), the state enum {IDLE, ACCESS, RESP, ERR_RESP}, and the RSP register ID 4'd4.
- Sub-module dmem_array: a MEM_BYTES byte array with one 64-bit little-endian synchronous write port (we, addr, wdata) and one 64-bit read port. It has no reset.
- The top module holds the FSM, the latency counter (width clog2(LATENCY+1)), the per-icode address/data mux and the range check.

## Test plan
- rmmovq with valE=16, valA=64'h1122334455667788, then mrmovq with valE=16. The load returns valM=64'h1122334455667788 and byte 16 holds 8'h88. out_valid rises 3 cycles after each capture (LATENCY=2).
- pushq with valE=24, valA=5, then popq with valA=24. Pop returns valM=5, and valE_q equals the popq valE input.
- mrmovq with valE=MEM_BYTES-7. Response: dmem_error=1, valM=0, memory unchanged, out_valid at capture+3. Repeat with valE=64'hFFFF_FFFF_FFFF_FFFC: same response, and the range check must not wrap.
- opq (icode 6) with valE=99 and cond=1. Response: out_valid at capture+1, valM=0, valE_q=99, cond_q=1, no memory write.
- Hold out_ready=0 for 5 cycles during RESP. All outputs stay stable and in_ready=0. Consume on the 6th cycle, after which in_ready returns to 1.
- Assert rst during ACCESS of rmmovq valE=0, valA=7. Target bytes keep their old value, state returns to IDLE, and out_valid=0 on the edge after reset.
